// File: rtl/bp_train_sequencer.sv
// Training-sample sequencer for the BackPropagationNN datapath.
// Buffers up to NUM_SAMPLES training vectors and presents each one to the
// network for HOLD_CYCLES clocks. On the last hold cycle it checks the
// network outputs against the target bits. Epochs repeat until one epoch
// has no errors or the epoch limit is reached.
module bp_train_sequencer #(
   parameter int DW          = 9,
   parameter int NUM_SAMPLES = 8,
   parameter int HOLD_CYCLES = 9,
   parameter int MAX_EPOCHS  = 16
) (
   input  logic                                CLK,
   input  logic                                RST,
   input  logic                                clear,
   input  logic                                load_valid,
   output logic                                load_ready,
   input  logic [DW-1:0]                       load_x0,
   input  logic [DW-1:0]                       load_x1,
   input  logic [DW-1:0]                       load_x2,
   input  logic [DW-1:0]                       load_x3,
   input  logic [DW-1:0]                       load_d0,
   input  logic [DW-1:0]                       load_d1,
   input  logic                                start,
   output logic [DW-1:0]                       nn_x0,
   output logic [DW-1:0]                       nn_x1,
   output logic [DW-1:0]                       nn_x2,
   output logic [DW-1:0]                       nn_x3,
   output logic [DW-1:0]                       nn_desired_y0,
   output logic [DW-1:0]                       nn_desired_y1,
   input  logic                                nn_y0,
   input  logic                                nn_y1,
   output logic                                present_valid,
   output logic [$clog2(NUM_SAMPLES)-1:0]      sample_idx,
   output logic [$clog2(MAX_EPOCHS):0]         epoch_count,
   output logic [$clog2(NUM_SAMPLES):0]        err_count,
   output logic                                busy,
   output logic                                done,
   output logic                                converged
);

   localparam int IW = $clog2(NUM_SAMPLES);
   localparam int CW = IW + 1;
   localparam int EW = $clog2(MAX_EPOCHS) + 1;
   localparam int HW = $clog2(HOLD_CYCLES);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [DW-1:0] mem_x0 [NUM_SAMPLES];
   logic [DW-1:0] mem_x1 [NUM_SAMPLES];
   logic [DW-1:0] mem_x2 [NUM_SAMPLES];
   logic [DW-1:0] mem_x3 [NUM_SAMPLES];
   logic [DW-1:0] mem_d0 [NUM_SAMPLES];
   logic [DW-1:0] mem_d1 [NUM_SAMPLES];

   logic [CW-1:0] sample_count;
   logic [HW-1:0] hold_q;
   logic [CW-1:0] acc_q;

   logic          load_fire;
   logic          start_ok;
   logic          last_hold;
   logic          last_sample;
   logic          mismatch;
   logic [CW-1:0] acc_next;
   logic [EW-1:0] epoch_inc;
   logic          stop_training;

   // Clear has priority over a load in the same cycle. A load that coincides
   // with start still counts toward the non-empty check.
   assign load_fire     = load_valid && load_ready && !clear;
   assign start_ok      = (state_q == IDLE) && start && !clear &&
                          ((sample_count != '0) || load_fire);
   assign last_hold     = (hold_q == HW'(HOLD_CYCLES - 1));
   assign last_sample   = ({1'b0, sample_idx} == (sample_count - 1'b1));
   assign mismatch      = last_hold &&
                          ((nn_y0 != mem_d0[sample_idx][0]) ||
                           (nn_y1 != mem_d1[sample_idx][0]));
   assign acc_next      = acc_q + CW'(mismatch);
   assign epoch_inc     = epoch_count + 1'b1;
   assign stop_training = (acc_next == '0) || (epoch_inc == EW'(MAX_EPOCHS));

   // Sample buffer. The contents are not reset, so a new start retrains on them.
   always_ff @(posedge CLK) begin
      if (load_fire) begin
         mem_x0[sample_count[IW-1:0]] <= load_x0;
         mem_x1[sample_count[IW-1:0]] <= load_x1;
         mem_x2[sample_count[IW-1:0]] <= load_x2;
         mem_x3[sample_count[IW-1:0]] <= load_x3;
         mem_d0[sample_count[IW-1:0]] <= load_d0;
         mem_d1[sample_count[IW-1:0]] <= load_d1;
      end
   end

   // State register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and state-decoded outputs. The network sees data only in PRESENT.
   always_comb begin
      state_d       = state_q;
      load_ready    = 1'b0;
      present_valid = 1'b0;
      busy          = 1'b0;
      done          = 1'b0;
      nn_x0         = '0;
      nn_x1         = '0;
      nn_x2         = '0;
      nn_x3         = '0;
      nn_desired_y0 = '0;
      nn_desired_y1 = '0;
      case (state_q)
         IDLE: begin
            load_ready = (sample_count < CW'(NUM_SAMPLES));
            if (start_ok) begin
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            present_valid = 1'b1;
            busy          = 1'b1;
            nn_x0         = mem_x0[sample_idx];
            nn_x1         = mem_x1[sample_idx];
            nn_x2         = mem_x2[sample_idx];
            nn_x3         = mem_x3[sample_idx];
            nn_desired_y0 = mem_d0[sample_idx];
            nn_desired_y1 = mem_d1[sample_idx];
            if (last_hold && last_sample && stop_training) begin
               state_d = DONE;
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Loading, hold timing, per-epoch error accumulation and result flags.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sample_count <= '0;
         sample_idx   <= '0;
         hold_q       <= '0;
         acc_q        <= '0;
         epoch_count  <= '0;
         err_count    <= '0;
         converged    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (clear) begin
                  sample_count <= '0;
               end else if (load_fire) begin
                  sample_count <= sample_count + 1'b1;
               end
               if (start_ok) begin
                  sample_idx  <= '0;
                  hold_q      <= '0;
                  acc_q       <= '0;
                  epoch_count <= '0;
                  converged   <= 1'b0;
               end
            end
            PRESENT: begin
               if (!last_hold) begin
                  hold_q <= hold_q + 1'b1;
               end else begin
                  hold_q <= '0;
                  if (last_sample) begin
                     err_count   <= acc_next;
                     epoch_count <= epoch_inc;
                     if (acc_next == '0) begin
                        converged <= 1'b1;
                     end else if (epoch_inc != EW'(MAX_EPOCHS)) begin
                        acc_q      <= '0;
                        sample_idx <= '0;
                     end
                  end else begin
                     acc_q      <= acc_next;
                     sample_idx <= sample_idx + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bp_train_sequencer.sv
// Directed testbench for bp_train_sequencer.
// A trivial network model either echoes the presented target bits or ties
// y0 high to force a mismatch on samples whose target y0 is 0.
module tb_bp_train_sequencer;

   localparam int DW = 9;
   localparam int NS = 8;
   localparam int HC = 9;
   localparam int ME = 16;

   logic          CLK = 1'b0;
   logic          RST;
   logic          clear;
   logic          load_valid;
   logic          load_ready;
   logic [DW-1:0] load_x0, load_x1, load_x2, load_x3, load_d0, load_d1;
   logic          start;
   logic [DW-1:0] nn_x0, nn_x1, nn_x2, nn_x3, nn_desired_y0, nn_desired_y1;
   logic          nn_y0, nn_y1;
   logic          present_valid;
   logic [2:0]    sample_idx;
   logic [4:0]    epoch_count;
   logic [3:0]    err_count;
   logic          busy, done, converged;
   logic          tieY0;

   int assertCount = 0;
   int failCount   = 0;
   int doneCyc;

   bp_train_sequencer #(
      .DW(DW), .NUM_SAMPLES(NS), .HOLD_CYCLES(HC), .MAX_EPOCHS(ME)
   ) dut (
      .CLK(CLK), .RST(RST), .clear(clear), .load_valid(load_valid),
      .load_ready(load_ready), .load_x0(load_x0), .load_x1(load_x1),
      .load_x2(load_x2), .load_x3(load_x3), .load_d0(load_d0), .load_d1(load_d1),
      .start(start), .nn_x0(nn_x0), .nn_x1(nn_x1), .nn_x2(nn_x2), .nn_x3(nn_x3),
      .nn_desired_y0(nn_desired_y0), .nn_desired_y1(nn_desired_y1),
      .nn_y0(nn_y0), .nn_y1(nn_y1), .present_valid(present_valid),
      .sample_idx(sample_idx), .epoch_count(epoch_count), .err_count(err_count),
      .busy(busy), .done(done), .converged(converged)
   );

   // Free-running 10-unit clock.
   always #5 CLK = ~CLK;

   // Network stand-in: answers with the target bits unless y0 is tied high.
   assign nn_y0 = tieY0 ? 1'b1 : nn_desired_y0[0];
   assign nn_y1 = nn_desired_y1[0];

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic applyStimulus(input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                                input logic [DW-1:0] x2, input logic [DW-1:0] x3,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic st);
      load_valid = 1'b1;
      load_x0 = x0; load_x1 = x1; load_x2 = x2; load_x3 = x3;
      load_d0 = d0; load_d1 = d1;
      start = st;
      tick();
      load_valid = 1'b0;
      start = 1'b0;
   endtask

   // Pulses start; returns at the negedge of the first PRESENT cycle (cycle 1).
   task automatic startRun;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Advances until done is seen or the bound expires; cyc is the done cycle or 0.
   task automatic waitDone(input int fromCyc, input int bound, output int cyc);
      cyc = 0;
      for (int c = fromCyc; c <= bound && cyc == 0; c++) begin
         if (done) cyc = c;
         else tick();
      end
   endtask

   initial begin
      RST = 1'b0; clear = 1'b0; load_valid = 1'b0; start = 1'b0; tieY0 = 1'b0;
      load_x0 = '0; load_x1 = '0; load_x2 = '0; load_x3 = '0;
      load_d0 = '0; load_d1 = '0;

      // Reset values.
      #12;
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_valid", present_valid, 0);
      checkOutput("rst_nn_x0", nn_x0, 0);
      checkOutput("rst_epoch", epoch_count, 0);
      checkOutput("rst_err", err_count, 0);
      checkOutput("rst_conv", converged, 0);
      checkOutput("rst_ready", load_ready, 1);
      @(negedge CLK);
      RST = 1'b1;
      tick();

      // Load two samples.
      checkOutput("load0_ready", load_ready, 1);
      applyStimulus(9'd196, 9'd243, 9'd106, 9'd149, 9'd0, 9'd0, 1'b0);
      checkOutput("load1_ready", load_ready, 1);
      applyStimulus(9'd13, 9'd37, 9'd128, 9'd160, 9'd1, 9'd0, 1'b0);
      checkOutput("load_after_ready", load_ready, 1);
      checkOutput("load_after_nn_x0", nn_x0, 0);
      checkOutput("load_after_valid", present_valid, 0);
      checkOutput("load_after_busy", busy, 0);

      // Convergence in one epoch.
      startRun();
      for (int c = 1; c <= 20; c++) begin
         if (c == 1) begin
            checkOutput("conv_c1_valid", present_valid, 1);
            checkOutput("conv_c1_idx", sample_idx, 0);
            checkOutput("conv_c1_x0", nn_x0, 196);
            checkOutput("conv_c1_x3", nn_x3, 149);
            checkOutput("conv_c1_d0", nn_desired_y0, 0);
         end
         if (c == 9) begin
            checkOutput("conv_c9_idx", sample_idx, 0);
            checkOutput("conv_c9_x1", nn_x1, 243);
         end
         if (c == 10) begin
            checkOutput("conv_c10_idx", sample_idx, 1);
            checkOutput("conv_c10_x0", nn_x0, 13);
            checkOutput("conv_c10_x2", nn_x2, 128);
            checkOutput("conv_c10_d0", nn_desired_y0, 1);
         end
         if (c == 18) begin
            checkOutput("conv_c18_idx", sample_idx, 1);
            checkOutput("conv_c18_done", done, 0);
         end
         if (c == 19) begin
            checkOutput("conv_c19_done", done, 1);
            checkOutput("conv_c19_busy", busy, 1);
            checkOutput("conv_c19_valid", present_valid, 0);
            checkOutput("conv_c19_x0", nn_x0, 0);
            checkOutput("conv_c19_conv", converged, 1);
            checkOutput("conv_c19_epoch", epoch_count, 1);
            checkOutput("conv_c19_err", err_count, 0);
         end
         if (c == 20) begin
            checkOutput("conv_c20_done", done, 0);
            checkOutput("conv_c20_busy", busy, 0);
            checkOutput("conv_c20_conv", converged, 1);
         end
         if (c < 20) tick();
      end

      // Non-convergence to the epoch limit, with ignored controls mid-run.
      tieY0 = 1'b1;
      startRun();
      doneCyc = 0;
      for (int c = 1; c <= 400 && doneCyc == 0; c++) begin
         if (c == 1) checkOutput("nc_conv_cleared", converged, 0);
         if (c == 5) begin
            start = 1'b1; load_valid = 1'b1; clear = 1'b1; load_x0 = 9'd77;
         end
         if (c == 6) begin
            start = 1'b0; load_valid = 1'b0; clear = 1'b0;
         end
         if (c == 19) begin
            checkOutput("nc_c19_idx", sample_idx, 0);
            checkOutput("nc_c19_epoch", epoch_count, 1);
            checkOutput("nc_c19_err", err_count, 1);
            checkOutput("nc_c19_valid", present_valid, 1);
         end
         if (done) doneCyc = c;
         else tick();
      end
      checkOutput("nc_done_cycle", doneCyc, 16 * 18 + 1);
      checkOutput("nc_epoch", epoch_count, 16);
      checkOutput("nc_err", err_count, 1);
      checkOutput("nc_conv", converged, 0);
      tick();

      // Asynchronous reset during epoch 2, hold cycle 4 (cycle 23).
      startRun();
      for (int c = 1; c < 23; c++) tick();
      checkOutput("mr_pre_idx", sample_idx, 0);
      checkOutput("mr_pre_epoch", epoch_count, 1);
      checkOutput("mr_pre_valid", present_valid, 1);
      RST = 1'b0;
      #1;
      checkOutput("mr_valid", present_valid, 0);
      checkOutput("mr_busy", busy, 0);
      checkOutput("mr_x0", nn_x0, 0);
      checkOutput("mr_epoch", epoch_count, 0);
      checkOutput("mr_err", err_count, 0);
      @(negedge CLK);
      RST = 1'b1;
      tick();
      checkOutput("mr_after_ready", load_ready, 1);
      checkOutput("mr_after_busy", busy, 0);

      // Fill the buffer; the ninth load must be dropped.
      tieY0 = 1'b0;
      for (int i = 0; i < NS; i++) begin
         checkOutput("full_ready", load_ready, 1);
         applyStimulus(9'(i * 3 + 1), 9'(i + 50), 9'(i + 100), 9'(i + 200),
                       9'(i & 1), 9'((i >> 1) & 1), 1'b0);
      end
      checkOutput("full_ready_low", load_ready, 0);
      applyStimulus(9'd300, 9'd301, 9'd302, 9'd303, 9'd1, 9'd1, 1'b0);
      checkOutput("full_ready_still_low", load_ready, 0);
      startRun();
      for (int c = 1; c < 64; c++) tick();
      checkOutput("full_c64_idx", sample_idx, 7);
      checkOutput("full_c64_x0", nn_x0, 22);
      waitDone(64, 200, doneCyc);
      checkOutput("full_done_cycle", doneCyc, 8 * 9 + 1);
      checkOutput("full_conv", converged, 1);
      tick();

      // Clear empties the buffer; clear beats a simultaneous load; empty start ignored.
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checkOutput("clr_ready", load_ready, 1);
      clear = 1'b1;
      applyStimulus(9'd1, 9'd2, 9'd3, 9'd4, 9'd0, 9'd0, 1'b0);
      clear = 1'b0;
      startRun();
      checkOutput("empty_busy", busy, 0);
      checkOutput("empty_valid", present_valid, 0);
      tick();
      tick();
      checkOutput("empty_busy_later", busy, 0);

      // Start in the same cycle as the first load: one-sample training.
      applyStimulus(9'd5, 9'd6, 9'd7, 9'd8, 9'd1, 9'd1, 1'b1);
      checkOutput("sl_valid", present_valid, 1);
      checkOutput("sl_idx", sample_idx, 0);
      checkOutput("sl_x0", nn_x0, 5);
      checkOutput("sl_d1", nn_desired_y1, 1);
      waitDone(1, 50, doneCyc);
      checkOutput("sl_done_cycle", doneCyc, 10);
      checkOutput("sl_conv", converged, 1);
      checkOutput("sl_err", err_count, 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
